// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Imported by mem_arbiter and rr_pick2.
package mem_arbiter_pkg;
    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic port_t;
    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select.
// On a tie the port that was not granted last wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);
    always_comb begin
        valid = req0 | req1;
        grant = PORT0;
        if (req0 && req1)
            grant = ~last_grant;
        else if (req1)
            grant = PORT1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory between the fetch port (0)
// and the load/store port (1), driving the start-pulse / ready handshake.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     rwn0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic                     req1,
    input  logic                     rwn1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     busy,
    output logic                     mem_start,
    output logic                     mem_rwn,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);
    state_t state;
    logic   last_grant;
    logic   granted;
    logic   pick_grant;
    logic   pick_valid;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Start follows ready within ISSUE so it fires in the first idle-memory cycle only.
    assign mem_start = (state == ISSUE) && mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            mem_rwn     <= 1'b1;
            mem_address <= '0;
            mem_data_in <= '0;
            rdata       <= '0;
            last_grant  <= PORT1;
            granted     <= PORT0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        granted     <= pick_grant;
                        mem_rwn     <= pick_grant ? rwn1   : rwn0;
                        mem_address <= pick_grant ? addr1  : addr0;
                        mem_data_in <= pick_grant ? wdata1 : wdata0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready)
                        state <= GUARD;
                end
                // Memory still shows ready this cycle; ignore it.
                GUARD: state <= BUSY;
                BUSY: begin
                    if (mem_ready) begin
                        if (mem_rwn)
                            rdata <= mem_data_out;
                        ack0  <= (granted == PORT0);
                        ack1  <= (granted == PORT1);
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= granted;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          rq [2];
    logic          rw [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];

    logic          ack0, ack1, busy, mem_start, mem_rwn, mem_ready;
    logic [DW-1:0] rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (rq[0]),
        .rwn0         (rw[0]),
        .addr0        (ad[0]),
        .wdata0       (wd[0]),
        .req1         (rq[1]),
        .rwn1         (rw[1]),
        .addr1        (ad[1]),
        .wdata1       (wd[1]),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata        (rdata),
        .busy         (busy),
        .mem_start    (mem_start),
        .mem_rwn      (mem_rwn),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready),
        .mem_data_out (mem_data_out)
    );

    // Memory environment: ready drops after an accepted start, returns N cycles later.
    logic          ready_r, hold, m_rwn;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] mem_arr [256];
    int            cnt;
    int            cur_n = 0;
    bit            rand_n = 1'b0;

    assign mem_ready = ready_r & ~hold;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r      <= 1'b1;
            cnt          <= 0;
            mem_data_out <= '0;
            m_rwn        <= 1'b1;
            m_addr       <= '0;
            m_data       <= '0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= DW'(i);
        end else if (mem_start && mem_ready) begin
            ready_r <= 1'b0;
            cnt     <= rand_n ? int'($urandom_range(0, 3)) : cur_n;
            m_rwn   <= mem_rwn;
            m_addr  <= mem_address;
            m_data  <= mem_data_in;
        end else if (!ready_r) begin
            if (cnt == 0) begin
                ready_r <= 1'b1;
                if (m_rwn) mem_data_out <= mem_arr[m_addr];
                else       mem_arr[m_addr] <= m_data;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] ref_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq[0] = 1'b0; rq[1] = 1'b0;
        hold = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
        tick();
    endtask

    typedef struct {
        logic          port;
        logic          rwn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            n;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, start_at, nstart, acks;
        bit got, other;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic srwn;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 32'h0,        0, 4, 32'h0000_0010};
        vecs[1] = '{1'b1, 1'b0, 8'h07, 32'hDEADBEEF, 3, 7, 32'h0000_0010};
        vecs[2] = '{1'b0, 1'b1, 8'h07, 32'h0,        1, 5, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 32'h0,        2, 6, 32'h0000_00FF};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 32'h12345678, 0, 4, 32'h0000_00FF};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 32'h0,        0, 4, 32'h12345678};

        rq[0] = 1'b0; rq[1] = 1'b0; rw[0] = 1'b1; rw[1] = 1'b1;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0; hold = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(mem_start), 0);
        check("rst_rwn", 32'(mem_rwn), 1);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_wdata", mem_data_in, 0);
        check("rst_rdata", rdata, 0);
        do_reset();

        // Directed single transactions
        foreach (vecs[k]) begin
            cur_n = vecs[k].n;
            rq[vecs[k].port] = 1'b1;
            rw[vecs[k].port] = vecs[k].rwn;
            ad[vecs[k].port] = vecs[k].addr;
            wd[vecs[k].port] = vecs[k].wdata;
            lat = 0; got = 0; other = 0; start_at = -1;
            sa = '0; sd = '0; srwn = 1'b0;
            while (lat < 20 && !got) begin
                tick();
                lat++;
                if (mem_start) begin
                    start_at = lat; sa = mem_address; sd = mem_data_in; srwn = mem_rwn;
                end
                if (vecs[k].port ? ack0 : ack1) other = 1;
                if (vecs[k].port ? ack1 : ack0) got = 1;
            end
            check($sformatf("v%0d_ack", k), 32'(got), 1);
            check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            check($sformatf("v%0d_other_ack", k), 32'(other), 0);
            check($sformatf("v%0d_start_cycle", k), start_at, 1);
            check($sformatf("v%0d_mem_address", k), 32'(sa), 32'(vecs[k].addr));
            check($sformatf("v%0d_mem_rwn", k), 32'(srwn), 32'(vecs[k].rwn));
            if (!vecs[k].rwn) check($sformatf("v%0d_mem_data_in", k), sd, vecs[k].wdata);
            check($sformatf("v%0d_rdata", k), rdata, vecs[k].rdata);
            rq[vecs[k].port] = 1'b0;
            tick();
        end

        // Tie after reset: grants alternate starting with port 0
        do_reset();
        cur_n = 0;
        rw[0] = 1'b1; rw[1] = 1'b1; ad[0] = 8'h40; ad[1] = 8'h41;
        rq[0] = 1'b1; rq[1] = 1'b1;
        acks = 0; lat = 0;
        while (acks < 4 && lat < 80) begin
            tick();
            lat++;
            if (ack0 && ack1) check("tie_both_ack", 1, 0);
            else if (ack0 || ack1) begin
                check($sformatf("tie_order%0d", acks), 32'(ack1), 32'(acks % 2));
                check($sformatf("tie_rdata%0d", acks), rdata, ack1 ? 32'h41 : 32'h40);
                acks++;
            end
        end
        check("tie_ack_count", acks, 4);
        rq[0] = 1'b0; rq[1] = 1'b0;
        tick();

        // Payload latched at grant; dropped req still acked
        cur_n = 1;
        rq[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h20;
        tick(); tick();
        ad[0] = 8'h30; rq[0] = 1'b0;
        tick();
        check("stab_mem_address", 32'(mem_address), 32'h20);
        got = 0; lat = 3;
        while (lat < 20 && !got) begin
            if (ack0) got = 1; else begin tick(); lat++; end
        end
        check("stab_ack0", 32'(got), 1);
        check("stab_rdata", rdata, 32'h20);
        tick();

        // Memory not ready at grant: start waits for ready
        cur_n = 0; hold = 1'b1;
        rq[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h05;
        lat = 0; got = 0; nstart = 0; start_at = -1;
        while (lat < 20 && !got) begin
            tick();
            lat++;
            if (lat == 4) begin hold = 1'b0; #1; end
            if (mem_start) begin nstart++; start_at = lat; end
            if (ack0) got = 1;
        end
        check("hold_start_count", nstart, 1);
        check("hold_start_cycle", start_at, 4);
        check("hold_ack_latency", lat, 7);
        check("hold_rdata", rdata, 32'h05);
        rq[0] = 1'b0;
        tick();

        // Reset in the middle of BUSY
        cur_n = 3;
        rq[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h33;
        tick(); tick(); tick();
        reset = 1'b1; rq[0] = 1'b0;
        #1;
        check("mid_rst_ack0", 32'(ack0), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(mem_start), 0);
        check("mid_rst_rwn", 32'(mem_rwn), 1);
        check("mid_rst_addr", 32'(mem_address), 0);
        check("mid_rst_rdata", rdata, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
        nstart = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack0 || ack1 || mem_start) nstart++;
        end
        check("post_rst_quiet", nstart, 0);
        cur_n = 2;
        rq[0] = 1'b1; ad[0] = 8'h10;
        lat = 0; got = 0;
        while (lat < 20 && !got) begin
            tick();
            lat++;
            if (ack0) got = 1;
        end
        check("post_rst_latency", lat, 6);
        check("post_rst_rdata", rdata, 32'h10);
        rq[0] = 1'b0;
        tick();

        // Randomized traffic against a transaction-level model
        do_reset();
        rand_n = 1'b1;
        begin
            int last = 1, pend = 0, wait_cnt = 0, ackp;
            bit free = 1, free_next = 1, waiting = 0, abort = 0;
            logic p_rwn;
            logic [AW-1:0] p_addr;
            logic [DW-1:0] p_wd, exp_rd;
            p_rwn = 1'b1; p_addr = '0; p_wd = '0; exp_rd = '0;
            for (int cyc = 0; cyc < 420 && !abort; cyc++) begin
                tick();
                free = free_next;
                ackp = ack0 ? 0 : (ack1 ? 1 : -1);
                if (ack0 && ack1) check("rand_both_ack", 1, 0);
                if (mem_start) begin
                    check("rand_mem_address", 32'(mem_address), 32'(p_addr));
                    check("rand_mem_rwn", 32'(mem_rwn), 32'(p_rwn));
                end
                if (ackp >= 0) begin
                    check("rand_ack_expected", 32'(waiting), 1);
                    check("rand_ack_port", ackp, pend);
                    if (p_rwn) check("rand_rdata", rdata, exp_rd);
                    else ref_mem[p_addr] = p_wd;
                    waiting = 0; free_next = 1;
                    rq[ackp] = 1'b0;
                end else if (waiting) begin
                    wait_cnt++;
                    if (wait_cnt > 20) begin
                        check("rand_ack_timeout", 0, 1);
                        abort = 1;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (!rq[p] && ackp != p && cyc < 370 && $urandom_range(0, 2) == 0) begin
                        rq[p] = 1'b1;
                        rw[p] = 1'($urandom_range(0, 1));
                        ad[p] = AW'($urandom_range(0, 15));
                        wd[p] = $urandom;
                    end
                end
                if (free && (rq[0] || rq[1])) begin
                    pend = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
                    last = pend;
                    p_rwn = rw[pend]; p_addr = ad[pend]; p_wd = wd[pend];
                    exp_rd = ref_mem[p_addr];
                    waiting = 1; wait_cnt = 0; free_next = 0;
                end
            end
            check("rand_drained", 32'(waiting), 0);
        end
        rq[0] = 1'b0; rq[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
